// File: rtl/leaf_loader_pkg.sv
// Shared types and width helpers for the leaf sequence loader and its arbiter.
// Widths derive from the top-level parameters via the helper functions below.
package leaf_loader_pkg;

  localparam int DEF_LEAF_CNT   = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_SEQ    = 128;
  localparam int DEF_TERM_CNT   = 4;

  // Stage-1 channel field is sized for up to 1024 leaves; the top zero-extends.
  localparam int CHAN_MAX_W = 10;

  function automatic int chan_w(input int leaf_cnt);
    return (leaf_cnt > 1) ? $clog2(leaf_cnt) : 1;
  endfunction

  function automatic int k_w(input int len_seq);
    return (len_seq > 1) ? $clog2(len_seq) : 1;
  endfunction

  function automatic int addr_w(input int leaf_cnt, input int len_seq);
    return $clog2(leaf_cnt * len_seq);
  endfunction

  function automatic int tc_w(input int term_cnt);
    return $clog2(term_cnt + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    TERM,
    DONE
  } chan_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_term;
    logic [CHAN_MAX_W-1:0] chan;
  } stg1_t;

endpackage

// File: rtl/leaf_seq_loader_arb.sv
// Round-robin arbiter: grants the first requester found searching cyclically
// from ptr_i; returns both a one-hot grant and its index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  always_comb begin
    int  idx;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_vld_o  = 1'b1;
        gnt_idx_o  = IDX_W'(idx);
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_seq_loader.sv
// Streams LEAF_CNT presorted sequences from a single-port memory into per-leaf
// FIFOs, round-robin with per-leaf backpressure, appending TERM_CNT terminators.
module leaf_seq_loader
  import leaf_loader_pkg::*;
#(
  parameter int                    LEAF_CNT   = DEF_LEAF_CNT,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    LEN_SEQ    = DEF_LEN_SEQ,
  parameter int                    TERM_CNT   = DEF_TERM_CNT,
  parameter logic [DATA_WIDTH-1:0] TERM_VAL   = '0,
  parameter int                    ADDR_W     = addr_w(LEAF_CNT, LEN_SEQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic [LEAF_CNT-1:0]   i_fifo_full,
  output logic [LEAF_CNT-1:0]   o_fifo_write,
  output logic [DATA_WIDTH-1:0] o_fifo_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CHAN_W = chan_w(LEAF_CNT);
  localparam int K_W    = k_w(LEN_SEQ);
  localparam int TC_W   = tc_w(TERM_CNT);

  chan_state_t       st_q [LEAF_CNT];
  chan_state_t       st_d [LEAF_CNT];
  logic [K_W-1:0]    k_q  [LEAF_CNT];
  logic [K_W-1:0]    k_d  [LEAF_CNT];
  logic [TC_W-1:0]   tc_q [LEAF_CNT];
  logic [TC_W-1:0]   tc_d [LEAF_CNT];

  logic [LEAF_CNT-1:0] req;
  logic [LEAF_CNT-1:0] gnt;
  logic [CHAN_W-1:0]   gnt_idx;
  logic                gnt_vld;
  logic [CHAN_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                busy_q;
  logic                done_q;
  logic                start_acc;
  logic                all_done;
  logic                fin;
  stg1_t               stg_p1_d;
  stg1_t               stg_p1_q;

  assign start_acc = i_start && !busy_q;

  always_comb begin
    all_done = 1'b1;
    for (int c = 0; c < LEAF_CNT; c++) begin
      req[c] = ((st_q[c] == LOAD) || (st_q[c] == TERM)) && !i_fifo_full[c];
      if (st_q[c] != DONE) all_done = 1'b0;
    end
  end

  // The final write is on the bus in the cycle where every channel first reads
  // DONE, so the done pulse registered here lands exactly one cycle later.
  assign fin = busy_q && all_done;

  rr_arbiter #(
    .N     (LEAF_CNT),
    .IDX_W (CHAN_W)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Stage 0: grant cycle -- memory read issued combinationally from the grant
  assign o_mem_rd   = gnt_vld && (st_q[gnt_idx] == LOAD);
  assign o_mem_addr = o_mem_rd ? ADDR_W'({gnt_idx, k_q[gnt_idx]}) : addr_q;

  always_comb begin
    for (int c = 0; c < LEAF_CNT; c++) begin
      st_d[c] = st_q[c];
      k_d[c]  = k_q[c];
      tc_d[c] = tc_q[c];
      if (start_acc) begin
        st_d[c] = LOAD;
        k_d[c]  = '0;
        tc_d[c] = '0;
      end else if (fin) begin
        st_d[c] = IDLE;
      end else if (gnt[c]) begin
        case (st_q[c])
          LOAD: begin
            if (k_q[c] == K_W'(LEN_SEQ - 1)) st_d[c] = TERM;
            else                             k_d[c]  = k_q[c] + K_W'(1);
          end
          TERM: begin
            if (tc_q[c] == TC_W'(TERM_CNT - 1)) st_d[c] = DONE;
            else                                tc_d[c] = tc_q[c] + TC_W'(1);
          end
          default: st_d[c] = st_q[c];
        endcase
      end
    end
  end

  always_comb begin
    stg_p1_d         = '0;
    stg_p1_d.valid   = gnt_vld;
    stg_p1_d.is_term = gnt_vld && (st_q[gnt_idx] == TERM);
    stg_p1_d.chan    = CHAN_MAX_W'(gnt_idx);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < LEAF_CNT; c++) begin
        st_q[c] <= IDLE;
        k_q[c]  <= '0;
        tc_q[c] <= '0;
      end
      ptr_q    <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stg_p1_q <= '0;
    end else begin
      for (int c = 0; c < LEAF_CNT; c++) begin
        st_q[c] <= st_d[c];
        k_q[c]  <= k_d[c];
        tc_q[c] <= tc_d[c];
      end
      if (gnt_vld) begin
        ptr_q <= (gnt_idx == CHAN_W'(LEAF_CNT - 1)) ? '0 : gnt_idx + CHAN_W'(1);
      end
      if (o_mem_rd) addr_q <= o_mem_addr;
      done_q   <= fin;
      if (start_acc)  busy_q <= 1'b1;
      else if (fin)   busy_q <= 1'b0;
      stg_p1_q <= stg_p1_d;
    end
  end

  // Stage 1: memory data returns; write the granted leaf FIFO
  assign o_fifo_write = stg_p1_q.valid ? (LEAF_CNT'(1) << stg_p1_q.chan) : '0;
  assign o_fifo_data  = stg_p1_q.is_term ? TERM_VAL : i_mem_data;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_leaf_seq_loader.sv
// Randomized scoreboard bench for leaf_seq_loader (4 leaves, 4 words, 2 terminators).
module tb_leaf_seq_loader;

  localparam int L   = 4;
  localparam int LS  = 4;
  localparam int TC  = 2;
  localparam int TOT = LS + TC;
  localparam logic [31:0] TV = 32'h0;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [3:0]  o_mem_addr;
  logic        o_mem_rd;
  logic [31:0] mem_dq;
  logic [3:0]  i_fifo_full = '0;
  logic [3:0]  o_fifo_write;
  logic [31:0] o_fifo_data;
  logic        o_busy;
  logic        o_done;

  always #5 clk = ~clk;

  leaf_seq_loader #(
    .LEAF_CNT   (L),
    .DATA_WIDTH (32),
    .LEN_SEQ    (LS),
    .TERM_CNT   (TC),
    .TERM_VAL   (TV)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .o_mem_addr   (o_mem_addr),
    .o_mem_rd     (o_mem_rd),
    .i_mem_data   (mem_dq),
    .i_fifo_full  (i_fifo_full),
    .o_fifo_write (o_fifo_write),
    .o_fifo_data  (o_fifo_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  logic [31:0] mem [16];
  always @(posedge clk) if (o_mem_rd) mem_dq <= mem[o_mem_addr];

  typedef struct {
    int          ch;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int prog [L];
  bit active = 0;
  bit busy_m = 0;
  int ptr_m = 0;
  int last_addr = 0;
  int done_cyc = -1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // Monitor: every presented write pops the oldest expected word
  always @(negedge clk) begin
    if (o_fifo_write !== 4'b0) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write cyc=%0d wr=%b data=%h required no write",
                 cyc, o_fifo_write, o_fifo_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (o_fifo_write !== 4'(1 << e.ch) || o_fifo_data !== e.d) begin
          fails++;
          $display("FAIL fifo_write cyc=%0d wr=%b data=%h required wr=%b data=%h",
                   cyc, o_fifo_write, o_fifo_data, 4'(1 << e.ch), e.d);
        end
      end
    end
  end

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) mem[i] = $urandom | 32'h1;
  endtask

  // One cycle: drive inputs, then predict this cycle's grant from the leaf
  // progress counters and compare the DUT's registered and read-side outputs.
  task automatic step(input bit st, input bit rs, input logic [3:0] fl);
    int g;
    int c;
    bit all_fin;
    logic exp_rd;
    logic [31:0] ed;
    @(negedge clk);
    i_start = st;
    i_rst = rs;
    i_fifo_full = fl;
    #1;
    cyc++;
    if (cyc == done_cyc) begin
      busy_m = 0;
      active = 0;
    end
    check("busy", 32'(o_busy), 32'(busy_m));
    check("done", 32'(o_done), 32'(cyc == done_cyc));
    g = -1;
    if (active) begin
      for (int i = 0; i < L; i++) begin
        c = (ptr_m + i) % L;
        if (g < 0 && prog[c] < TOT && !fl[c]) g = c;
      end
    end
    exp_rd = (g >= 0) && (prog[g] < LS);
    if (exp_rd) last_addr = g * LS + prog[g];
    check("mem_rd", 32'(o_mem_rd), 32'(exp_rd));
    check("mem_addr", 32'(o_mem_addr), 32'(last_addr[3:0]));
    if (g >= 0) begin
      ed = (prog[g] < LS) ? mem[g * LS + prog[g]] : TV;
      prog[g]++;
      ptr_m = (g + 1) % L;
      if (!rs) q.push_back('{g, ed});
      all_fin = 1;
      for (int i = 0; i < L; i++) if (prog[i] != TOT) all_fin = 0;
      if (all_fin) done_cyc = cyc + 2;
    end
    if (rs) begin
      busy_m = 0;
      active = 0;
      ptr_m = 0;
      last_addr = 0;
      done_cyc = -1;
    end else if (st && !busy_m) begin
      busy_m = 1;
      active = 1;
      for (int i = 0; i < L; i++) prog[i] = 0;
    end
  endtask

  task automatic run(input int mode, input int budget);
    logic [3:0] fl;
    bit st;
    rand_mem();
    for (int i = 0; i < budget; i++) begin
      case (mode)
        1:       fl = (i <= 30) ? 4'b0100 : 4'b0000;
        2:       fl = (i < 40) ? 4'b1101 : 4'b0000;
        3:       fl = 4'($urandom) & 4'($urandom);
        default: fl = 4'b0000;
      endcase
      st = (i == 0) || (mode == 4 && i < 20 && $urandom_range(0, 2) == 0);
      step(st, 1'b0, fl);
      if (!busy_m) return;
    end
    tests++;
    fails++;
    $display("FAIL run_timeout mode=%0d busy=%b required finish within %0d cycles",
             mode, o_busy, budget);
    step(1'b0, 1'b1, 4'b0);
  endtask

  initial begin
    repeat (3) step(1'b0, 1'b1, 4'b0);
    repeat (2) step(1'b0, 1'b0, 4'b0);
    check("rst_write", 32'(o_fifo_write), 32'h0);

    run(0, 100);
    run(1, 150);
    run(2, 150);
    run(3, 300);
    run(4, 200);
    run(3, 300);

    // Reset in the middle of a run, then restart from leaf 0
    rand_mem();
    step(1'b1, 1'b0, 4'b0);
    repeat (9) step(1'b0, 1'b0, 4'($urandom));
    step(1'b0, 1'b1, 4'b0);
    step(1'b0, 1'b0, 4'b0);
    check("post_rst_write", 32'(o_fifo_write), 32'h0);
    run(0, 100);

    // Start coinciding with reset must leave the loader idle
    step(1'b1, 1'b1, 4'b0);
    repeat (3) step(1'b0, 1'b0, 4'b0);

    repeat (2) step(1'b0, 1'b0, 4'b0);
    check("queue_empty", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
